arb_mux_n: RTL and testbench
============================

Name: arb_mux_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Supersedes the fixed 2/3/4-input datapath muxes wherever a source may stall or a sink may back-pressure, e.g. writeback-source and forwarding selection in the pipelined datapath.
- Channel choice is either an external select (MODE 0) or internal round-robin arbitration (MODE 1).
- One output register stage; sustains one transfer per cycle.

Parameters:
- N, 4, number of input channels (2..16)
- W, 32, data width in bits
- MODE, 0, 0 = external select via sel; 1 = round-robin arbitration (sel ignored)
- SEL_W, $clog2(N), derived localparam; width of sel, out_src and the round-robin pointer

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit high per cycle
- sel  input  SEL_W  channel select, used in MODE 0 only
- out_data  output  W  registered selected data
- out_src  output  SEL_W  index of the channel that produced out_data
- out_valid  output  1  output holds a beat
- out_ready  input  1  sink accepts the beat

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream): out_valid=0, out_data=0, out_src=0, rr_ptr=0. An in-flight beat is discarded and not replayed.
- Output-stage states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load_en = !out_valid || out_ready.
- Grant selection:
  - MODE 0: g = sel. has_req = (sel < N) && in_valid[sel].
  - MODE 1: g = first i with in_valid[i] set, scanning rr_ptr, rr_ptr+1, ... mod N. has_req = |in_valid.
- in_ready[i] = load_en && has_req && (i == g). This is combinational from out_ready, in_valid and sel.
- Transfer on a channel = in_valid[i] && in_ready[i]. On a transfer, next cycle out_data = in_data[g], out_src = g, out_valid = 1.
- State transitions:
  - EMPTY -> FULL on a transfer.
  - FULL with out_ready=1 and a new transfer -> FULL with the new beat (back-to-back, no bubble).
  - FULL with out_ready=1 and no transfer -> EMPTY.
  - FULL with out_ready=0 -> hold out_data, out_src and out_valid stable; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Round-robin pointer (MODE 1):
  - On a transfer, rr_ptr <= (g == N-1) ? 0 : g+1. This wraps for non-power-of-2 N.
  - Otherwise rr_ptr holds.
- MODE 0 with sel >= N (non-power-of-2 N): no grant, all in_ready=0, output drains normally. Not an error.
- sel may change every cycle. Only the value present in the transfer cycle matters; a change while stalled does not alter the held beat.
- No combinational path from in_data to out_data.

Optional Feature:
- Macro: ARB_MUX_N_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt, N*16 bits, one 16-bit counter per channel at [i*16 +: 16].
  - Counter i increments on each transfer from channel i and wraps from 16'hFFFF to 0.
  - All counters reset to 0 on rst_n low.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg holds:
  - typedef enum logic {MUX_SEL_EXT=0, MUX_SEL_RR=1} mux_mode_e
  - localparam GRANT_CNT_W = 16
  - a function rr_next(ptr, n) implementing the wrap-around increment
- One sub-module, rr_pick: combinational first-set-bit search from a start pointer over N bits, with outputs g and has_req. Used only when MODE=1.
- The output register and handshake logic stay in arb_mux_n.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 immediately (asynchronous); the beat is not re-emitted after release.
- MODE 0, N=4, W=32: sel=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEADBEEF, out_src=2, out_valid=1.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles while in_valid=4'b1111 and sel toggles -> in_ready=0 and out_data/out_src unchanged for all 3 cycles. When out_ready goes to 1, the new beat is loaded the same cycle.
- MODE 1, N=3: in_valid=3'b111 held, out_ready=1 -> out_src sequence 0,1,2,0,1 (wrap); grants every cycle with no bubbles.
- MODE 1 with a gap: rr_ptr=1, in_valid=3'b001 -> grant to 0 (scan wraps) and rr_ptr becomes 1. Then with in_valid=3'b101 -> grant 2.
- MODE 0, N=3, sel=3 -> in_ready=0 forever, out_valid falls after the current beat drains. With ARB_MUX_N_GRANT_CNT_EN, 65536 grants on channel 1 -> grant_cnt[1] returns to 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arb_mux_n selectable/arbitrated mux.
package mux_pkg;

    typedef enum logic {
        MUX_SEL_EXT = 1'b0,
        MUX_SEL_RR  = 1'b1
    } mux_mode_e;

    localparam int GRANT_CNT_W = 16;

    // Wrap-around increment that also works when n is not a power of two.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// First-set-bit search over req, scanning start, start+1, ... modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] g,
    output logic             has_req
);

    int idx;

    // Scan from the far end so the candidate closest to start wins last.
    always_comb begin
        g       = '0;
        has_req = |req;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (req[idx]) g = SEL_W'(idx);
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel registered mux with valid/ready on every port; external select or round-robin.
// Define ARB_MUX_N_GRANT_CNT_EN to add per-channel 16-bit grant counters on grant_cnt.
module arb_mux_n
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 32,
    parameter  int MODE  = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_src,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ARB_MUX_N_GRANT_CNT_EN
    ,
    output logic [N*GRANT_CNT_W-1:0] grant_cnt
`endif
);

    // state    | meaning
    // ST_EMPTY | output register holds no beat
    // ST_FULL  | output register holds a beat awaiting out_ready
    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    localparam int NP = 1 << SEL_W;

    state_e           state;
    logic             load_en;
    logic             has_req;
    logic             xfer;
    logic [SEL_W-1:0] g;
    logic [W-1:0]     sel_data;

    assign out_valid = (state == ST_FULL);
    assign load_en   = !out_valid || out_ready;
    assign xfer      = load_en && has_req;

    generate
        if (MODE == int'(MUX_SEL_RR)) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;

            rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
                .req     (in_valid),
                .start   (rr_ptr),
                .g       (g),
                .has_req (has_req)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rr_ptr <= '0;
                end else if (xfer) begin
                    rr_ptr <= SEL_W'(rr_next(32'(g), N));
                end
            end
        end else begin : g_ext
            logic [NP-1:0] valid_pad;

            // Pad so an out-of-range sel reads a zero valid instead of indexing past N.
            assign valid_pad = NP'(in_valid);
            assign g         = sel;
            assign has_req   = (int'(sel) < N) && valid_pad[sel];
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready = N'(1) << g;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SEL_W'(i)) sel_data = in_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer) begin
                        state    <= ST_FULL;
                        out_data <= sel_data;
                        out_src  <= g;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (xfer) begin
                            out_data <= sel_data;
                            out_src  <= g;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

`ifdef ARB_MUX_N_GRANT_CNT_EN
    generate
        for (genvar i = 0; i < N; i++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] <= '0;
                end else if (xfer && g == SEL_W'(i)) begin
                    grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] <=
                        grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] + 1'b1;
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: three instances (ext N=4, rr N=3, ext N=3) against a queue-free behavioural model.
// Grant-counter checks are active when ARB_MUX_N_GRANT_CNT_EN is defined.
module tb_arb_mux_n;

    localparam int NK [3] = '{4, 3, 3};
    localparam int MK [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] d0_data;  logic [3:0] d0_valid, d0_ready; logic [1:0] d0_sel, d0_osrc;
    logic [31:0]  d0_odata; logic d0_ovalid, d0_oready;
    logic [95:0]  d1_data;  logic [2:0] d1_valid, d1_ready; logic [1:0] d1_sel, d1_osrc;
    logic [31:0]  d1_odata; logic d1_ovalid, d1_oready;
    logic [95:0]  d2_data;  logic [2:0] d2_valid, d2_ready; logic [1:0] d2_sel, d2_osrc;
    logic [31:0]  d2_odata; logic d2_ovalid, d2_oready;
`ifdef ARB_MUX_N_GRANT_CNT_EN
    logic [63:0] d0_cnt;
    logic [47:0] d1_cnt, d2_cnt;
`endif

    arb_mux_n #(.N(4), .W(32), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0_data), .in_valid(d0_valid), .in_ready(d0_ready),
        .sel(d0_sel), .out_data(d0_odata), .out_src(d0_osrc), .out_valid(d0_ovalid),
        .out_ready(d0_oready)
`ifdef ARB_MUX_N_GRANT_CNT_EN
        , .grant_cnt(d0_cnt)
`endif
    );

    arb_mux_n #(.N(3), .W(32), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
        .sel(d1_sel), .out_data(d1_odata), .out_src(d1_osrc), .out_valid(d1_ovalid),
        .out_ready(d1_oready)
`ifdef ARB_MUX_N_GRANT_CNT_EN
        , .grant_cnt(d1_cnt)
`endif
    );

    arb_mux_n #(.N(3), .W(32), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_ready),
        .sel(d2_sel), .out_data(d2_odata), .out_src(d2_osrc), .out_valid(d2_ovalid),
        .out_ready(d2_oready)
`ifdef ARB_MUX_N_GRANT_CNT_EN
        , .grant_cnt(d2_cnt)
`endif
    );

    // Model state: what each output register must hold, plus rr pointer and grant tallies.
    bit          m_v [3];
    logic [31:0] m_d [3];
    int          m_s [3];
    int          m_p [3];
    int          m_c [3][4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void pick(input int n, input int mode, input int s, input logic [3:0] v,
                                 input int ptr, output int g, output bit hr);
        g  = 0;
        hr = 1'b0;
        if (mode == 0) begin
            if (s < n && v[s]) begin g = s; hr = 1'b1; end
        end else begin
            for (int k = 0; k < n; k++) begin
                if (!hr && v[(ptr + k) % n]) begin g = (ptr + k) % n; hr = 1'b1; end
            end
        end
    endfunction

    function automatic void get_in(input int k, output logic [3:0] v, output int s,
                                   output logic [127:0] d, output bit ordy);
        case (k)
            0:       begin v = d0_valid;       s = int'(d0_sel); d = d0_data;        ordy = d0_oready; end
            1:       begin v = {1'b0, d1_valid}; s = int'(d1_sel); d = {32'h0, d1_data}; ordy = d1_oready; end
            default: begin v = {1'b0, d2_valid}; s = int'(d2_sel); d = {32'h0, d2_data}; ordy = d2_oready; end
        endcase
    endfunction

    function automatic void get_out(input int k, output logic [31:0] od, output int os,
                                    output logic ov, output logic [3:0] rdy);
        case (k)
            0:       begin od = d0_odata; os = int'(d0_osrc); ov = d0_ovalid; rdy = d0_ready;         end
            1:       begin od = d1_odata; os = int'(d1_osrc); ov = d1_ovalid; rdy = {1'b0, d1_ready}; end
            default: begin od = d2_odata; os = int'(d2_osrc); ov = d2_ovalid; rdy = {1'b0, d2_ready}; end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_v[k] <= 1'b0; m_d[k] <= '0; m_s[k] <= 0; m_p[k] <= 0;
                for (int c = 0; c < 4; c++) m_c[k][c] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] v; int s; logic [127:0] d; bit ordy; int g; bit hr;
                get_in(k, v, s, d, ordy);
                pick(NK[k], MK[k], s, v, m_p[k], g, hr);
                if (!m_v[k] || ordy) begin
                    if (hr) begin
                        m_v[k] <= 1'b1;
                        m_d[k] <= d[g*32 +: 32];
                        m_s[k] <= g;
                        if (MK[k] == 1) m_p[k] <= (g + 1) % NK[k];
                        m_c[k][g] <= (m_c[k][g] + 1) % 65536;
                    end else begin
                        m_v[k] <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] v; int s; logic [127:0] d; bit ordy; int g; bit hr;
                logic [31:0] od; int os; logic ov; logic [3:0] rdy, erdy;
                get_in(k, v, s, d, ordy);
                get_out(k, od, os, ov, rdy);
                pick(NK[k], MK[k], s, v, m_p[k], g, hr);
                erdy = ((!m_v[k] || ordy) && hr) ? (4'b0001 << g) : 4'b0000;
                chk($sformatf("u%0d in_ready", k), 128'(rdy), 128'(erdy));
                chk($sformatf("u%0d out_valid", k), 128'(ov), 128'(m_v[k]));
                if (m_v[k]) begin
                    chk($sformatf("u%0d out_data", k), 128'(od), 128'(m_d[k]));
                    chk($sformatf("u%0d out_src", k), 128'(os), 128'(m_s[k]));
                end
`ifdef ARB_MUX_N_GRANT_CNT_EN
                for (int c = 0; c < NK[k]; c++) begin
                    logic [15:0] gc;
                    gc = (k == 0) ? d0_cnt[c*16 +: 16] : (k == 1) ? d1_cnt[c*16 +: 16] : d2_cnt[c*16 +: 16];
                    chk($sformatf("u%0d grant_cnt[%0d]", k, c), 128'(gc), 128'(m_c[k][c]));
                end
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        d0_valid = '0; d1_valid = '0; d2_valid = '0;
    endtask

    initial begin
        int rr_exp [5] = '{0, 1, 2, 0, 1};
        d0_data = '0; d1_data = '0; d2_data = '0;
        d0_sel = '0; d1_sel = '0; d2_sel = '0;
        d0_oready = 1'b0; d1_oready = 1'b0; d2_oready = 1'b0;
        idle_all();
        repeat (3) cyc();
        chk("reset u0 out_valid", 128'(d0_ovalid), 128'(0));
        chk("reset u0 out_data", 128'(d0_odata), 128'(0));
        chk("reset u1 out_src", 128'(d1_osrc), 128'(0));
        rst_n = 1'b1;
        cyc();

        // External select, single beat, then back-pressure with sel toggling.
        d0_sel = 2'd2; d0_valid = 4'b0100; d0_data[95:64] = 32'hDEADBEEF; d0_oready = 1'b1;
        #1 chk("ext in_ready", 128'(d0_ready), 128'(4'b0100));
        cyc();
        chk("ext out_data", 128'(d0_odata), 128'(32'hDEADBEEF));
        chk("ext out_src", 128'(d0_osrc), 128'(2));
        chk("ext out_valid", 128'(d0_ovalid), 128'(1));
        d0_valid = 4'b1111; d0_oready = 1'b0; d0_sel = 2'd0;
        d0_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready", 128'(d0_ready), 128'(0));
            chk("bp out_data", 128'(d0_odata), 128'(32'hDEADBEEF));
            chk("bp out_src", 128'(d0_osrc), 128'(2));
            cyc();
            d0_sel = 2'(i + 1);
        end
        d0_oready = 1'b1; d0_sel = 2'd1; d0_data[63:32] = 32'h11112222;
        #1 chk("bp release in_ready", 128'(d0_ready), 128'(4'b0010));
        cyc();
        chk("bp release out_data", 128'(d0_odata), 128'(32'h11112222));
        d0_valid = '0;
        cyc();

        // Round-robin, N=3, all requesting, then gaps that force the scan to wrap.
        d1_valid = 3'b111; d1_oready = 1'b1; d1_data = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr out_src", 128'(d1_osrc), 128'(rr_exp[i]));
            chk("rr out_valid", 128'(d1_ovalid), 128'(1));
        end
        d1_valid = 3'b001;
        cyc();
        chk("rr wrap src", 128'(d1_osrc), 128'(0));
        cyc();
        chk("rr gap src", 128'(d1_osrc), 128'(0));
        d1_valid = 3'b101;
        cyc();
        chk("rr skip src", 128'(d1_osrc), 128'(2));
        chk("rr skip data", 128'(d1_odata), 128'(32'hC2C2C2C2));
        d1_valid = '0;
        cyc();

        // External select out of range on N=3.
        d2_sel = 2'd1; d2_valid = 3'b010; d2_oready = 1'b0; d2_data = {$urandom, $urandom, $urandom};
        cyc();
        d2_sel = 2'd3; d2_valid = 3'b111;
        #1 chk("oor held valid", 128'(d2_ovalid), 128'(1));
        chk("oor in_ready stalled", 128'(d2_ready), 128'(0));
        cyc();
        d2_oready = 1'b1;
        #1 chk("oor in_ready draining", 128'(d2_ready), 128'(0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("oor out_valid", 128'(d2_ovalid), 128'(0));
            chk("oor in_ready", 128'(d2_ready), 128'(0));
        end

        // Random traffic on all three instances, checked cycle by cycle by the model.
        for (int i = 0; i < 800; i++) begin
            cyc();
            d0_valid = 4'($urandom); d0_sel = 2'($urandom_range(0, 3));
            d0_data = {$urandom, $urandom, $urandom, $urandom}; d0_oready = ($urandom_range(0, 3) != 0);
            d1_valid = 3'($urandom); d1_sel = 2'($urandom_range(0, 3));
            d1_data = {$urandom, $urandom, $urandom}; d1_oready = ($urandom_range(0, 3) != 0);
            d2_valid = 3'($urandom); d2_sel = 2'($urandom_range(0, 3));
            d2_data = {$urandom, $urandom, $urandom}; d2_oready = ($urandom_range(0, 2) != 0);
        end

        // Asynchronous reset in the middle of a held beat; the beat must not come back.
        cyc();
        idle_all();
        d0_valid = 4'b1111; d0_sel = 2'd0; d0_oready = 1'b0;
        cyc(); cyc();
        chk("mid reset pre out_valid", 128'(d0_ovalid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 128'(d0_ovalid), 128'(0));
        chk("mid reset out_data", 128'(d0_odata), 128'(0));
        chk("mid reset out_src", 128'(d0_osrc), 128'(0));
        d0_valid = '0; d0_oready = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("post reset no replay", 128'(d0_ovalid), 128'(0));

`ifdef ARB_MUX_N_GRANT_CNT_EN
        d0_sel = 2'd1; d0_valid = 4'b0010; d0_oready = 1'b1;
        repeat (65535) cyc();
        chk("grant_cnt[1] at ffff", 128'(d0_cnt[31:16]), 128'(16'hFFFF));
        cyc();
        d0_valid = '0;
        chk("grant_cnt[1] wrap", 128'(d0_cnt[31:16]), 128'(0));
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
